mealy_stream_sequencer: RTL and testbench



---
 rtl/mealy_stream_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_mealy_stream_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mealy_stream_sequencer.sv
// -----------------------------------------------------------------------------
// mealy_stream_sequencer
//
// Word-level controller around a serial 3-bit-history pattern detector.
// A W-bit word is accepted over a valid/ready handshake and shifted LSB-first
// through the detector, one bit per clock.  For every bit the detector reports
// whether the last three bits (oldest..newest) formed 1,1,1 (hi) or 0,0,1 (lo).
// Per-bit hit masks and hit counts are collected and presented as one result
// per word over a second valid/ready handshake.
//
// Ports
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   in_valid     in   producer offers in_data
//   in_ready     out  block can accept a word (decodes IDLE)
//   in_data      in   W-bit word, bit 0 scanned first
//   carry_hist   in   1: keep detector history from previous word, 0: clear it
//   out_valid    out  result available (decodes DONE)
//   out_ready    in   consumer takes the result
//   out_mask_hi  out  bit k set if word bit k completed 1,1,1
//   out_mask_lo  out  bit k set if word bit k completed 0,0,1
//   out_cnt_hi   out  popcount of out_mask_hi
//   out_cnt_lo   out  popcount of out_mask_lo
//   busy         out  high in SHIFT or DONE
// -----------------------------------------------------------------------------
module mealy_stream_sequencer #(
   parameter int W  = 10,
   parameter int CW = $clog2(W + 1)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic          carry_hist,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_mask_hi,
   output logic [W-1:0]  out_mask_lo,
   output logic [CW-1:0] out_cnt_hi,
   output logic [CW-1:0] out_cnt_lo,
   output logic          busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t          state_q,    state_d;
   logic [W-1:0]    shreg_q,    shreg_d;
   logic [CW-1:0]   bit_idx_q,  bit_idx_d;
   logic            ff1_q,      ff1_d;
   logic            ff2_q,      ff2_d;
   logic [1:0]      hist_cnt_q, hist_cnt_d;
   logic [W-1:0]    mask_hi_q,  mask_hi_d;
   logic [W-1:0]    mask_lo_q,  mask_lo_d;
   logic [CW-1:0]   cnt_hi_q,   cnt_hi_d;
   logic [CW-1:0]   cnt_lo_q,   cnt_lo_d;

   logic            bit_s;
   logic            hist_full_s;
   logic            hi_s;
   logic            lo_s;

   // Mealy detector outputs for the bit currently at the head of the shift register.
   // Matches are suppressed until two history bits exist since the last clear.
   always_comb begin
      bit_s       = shreg_q[0];
      hist_full_s = (hist_cnt_q == 2'd2);
      hi_s        = bit_s &  ff1_q &  ff2_q & hist_full_s;
      lo_s        = bit_s & ~ff1_q & ~ff2_q & hist_full_s;
   end

   // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_idx_d  = bit_idx_q;
      ff1_d      = ff1_q;
      ff2_d      = ff2_q;
      hist_cnt_d = hist_cnt_q;
      mask_hi_d  = mask_hi_q;
      mask_lo_d  = mask_lo_q;
      cnt_hi_d   = cnt_hi_q;
      cnt_lo_d   = cnt_lo_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               shreg_d   = in_data;
               bit_idx_d = {CW{1'b0}};
               mask_hi_d = {W{1'b0}};
               mask_lo_d = {W{1'b0}};
               cnt_hi_d  = {CW{1'b0}};
               cnt_lo_d  = {CW{1'b0}};
               if (!carry_hist) begin
                  ff1_d      = 1'b0;
                  ff2_d      = 1'b0;
                  hist_cnt_d = 2'd0;
               end else begin
                  ff1_d      = ff1_q;
                  ff2_d      = ff2_q;
                  hist_cnt_d = hist_cnt_q;
               end
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SHIFT: begin
            // Masks fill from the top: after W shifts, entry k holds the hit of word bit k.
            mask_hi_d = {hi_s, mask_hi_q[W-1:1]};
            mask_lo_d = {lo_s, mask_lo_q[W-1:1]};
            cnt_hi_d  = cnt_hi_q + CW'(hi_s);
            cnt_lo_d  = cnt_lo_q + CW'(lo_s);
            shreg_d   = {1'b0, shreg_q[W-1:1]};
            ff2_d     = ff1_q;
            ff1_d     = bit_s;
            if (hist_full_s) begin
               hist_cnt_d = 2'd2;
            end else begin
               hist_cnt_d = hist_cnt_q + 2'd1;
            end
            bit_idx_d = bit_idx_q + {{(CW-1){1'b0}}, 1'b1};
            if (bit_idx_q == CW'(W - 1)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end

         ST_DONE: begin
            // Result and history are held until the consumer takes the word.
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial result.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         shreg_q    <= {W{1'b0}};
         bit_idx_q  <= {CW{1'b0}};
         ff1_q      <= 1'b0;
         ff2_q      <= 1'b0;
         hist_cnt_q <= 2'd0;
         mask_hi_q  <= {W{1'b0}};
         mask_lo_q  <= {W{1'b0}};
         cnt_hi_q   <= {CW{1'b0}};
         cnt_lo_q   <= {CW{1'b0}};
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_idx_q  <= bit_idx_d;
         ff1_q      <= ff1_d;
         ff2_q      <= ff2_d;
         hist_cnt_q <= hist_cnt_d;
         mask_hi_q  <= mask_hi_d;
         mask_lo_q  <= mask_lo_d;
         cnt_hi_q   <= cnt_hi_d;
         cnt_lo_q   <= cnt_lo_d;
      end
   end

   // Handshake and status outputs decode the registered state directly.
   always_comb begin
      in_ready    = (state_q == ST_IDLE);
      out_valid   = (state_q == ST_DONE);
      busy        = (state_q != ST_IDLE);
      out_mask_hi = mask_hi_q;
      out_mask_lo = mask_lo_q;
      out_cnt_hi  = cnt_hi_q;
      out_cnt_lo  = cnt_lo_q;
   end

endmodule

// File: tb/tb_mealy_stream_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mealy_stream_sequencer
//
// Self-checking bench: directed words from the test plan plus randomized words,
// each compared with a reference model that treats the detector as a bit
// stream (queue of bits since the last history clear) and looks at the last
// three bits of that stream for every scanned bit.
// -----------------------------------------------------------------------------
module tb_mealy_stream_sequencer;

   localparam int W  = 10;
   localparam int CW = $clog2(W + 1);

   logic          clock;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          carry_hist;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_mask_hi;
   logic [W-1:0]  out_mask_lo;
   logic [CW-1:0] out_cnt_hi;
   logic [CW-1:0] out_cnt_lo;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;

   // model: bit stream seen since the last history clear
   logic stream_q[$];

   // results of the most recent word (model side)
   logic [W-1:0] exp_hi, exp_lo;
   int           exp_chi, exp_clo;

   mealy_stream_sequencer #(.W(W), .CW(CW)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .carry_hist  (carry_hist),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_mask_hi (out_mask_hi),
      .out_mask_lo (out_mask_lo),
      .out_cnt_hi  (out_cnt_hi),
      .out_cnt_lo  (out_cnt_lo),
      .busy        (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: scan word bits in order through the stream and test the last three bits.
   task automatic model_word(input logic [W-1:0] d, input logic c);
      int n;
      exp_hi = '0;
      exp_lo = '0;
      if (!c) stream_q.delete();
      for (int k = 0; k < W; k++) begin
         stream_q.push_back(d[k]);
         n = stream_q.size();
         if (n >= 3) begin
            if (stream_q[n-3] == 1'b1 && stream_q[n-2] == 1'b1 && stream_q[n-1] == 1'b1)
               exp_hi[k] = 1'b1;
            if (stream_q[n-3] == 1'b0 && stream_q[n-2] == 1'b0 && stream_q[n-1] == 1'b1)
               exp_lo[k] = 1'b1;
         end
         if (n > 3) void'(stream_q.pop_front());
      end
      exp_chi = $countones(exp_hi);
      exp_clo = $countones(exp_lo);
   endtask

   task automatic check_result(input string tag);
      check({tag, ".mhi"}, 32'(out_mask_hi), 32'(exp_hi));
      check({tag, ".mlo"}, 32'(out_mask_lo), 32'(exp_lo));
      check({tag, ".chi"}, 32'(out_cnt_hi),  32'(exp_chi));
      check({tag, ".clo"}, 32'(out_cnt_lo),  32'(exp_clo));
   endtask

   // Sends one word, waits for the result, stalls 'stall' cycles with out_ready low
   // while offering junk words, then completes the handshake.
   task automatic run_word(input string tag, input logic [W-1:0] d, input logic c, input int stall);
      int wt;
      int lat;
      wt = 0;
      while (!in_ready && wt < 50) begin
         @(posedge clock); #1; wt++;
      end
      check({tag, ".rdy"}, 32'(in_ready), 32'd1);
      in_valid   = 1'b1;
      in_data    = d;
      carry_hist = c;
      @(posedge clock); #1;
      in_valid   = 1'b0;
      in_data    = W'($urandom);
      carry_hist = 1'($urandom);
      model_word(d, c);
      check({tag, ".busy"}, 32'(busy), 32'd1);
      lat = 0;
      while (!out_valid && lat < 4 * W) begin
         @(posedge clock); #1; lat++;
      end
      // out_valid rises after the W-th edge following the accept edge
      check({tag, ".lat"}, 32'(lat), 32'(W));
      check_result(tag);
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         in_data  = W'($urandom);
         @(posedge clock); #1;
         check({tag, ".stall_ov"}, 32'(out_valid), 32'd1);
         check({tag, ".stall_ir"}, 32'(in_ready),  32'd0);
         check({tag, ".stall_mh"}, 32'(out_mask_hi), 32'(exp_hi));
         check({tag, ".stall_ml"}, 32'(out_mask_lo), 32'(exp_lo));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      check({tag, ".ov_drop"}, 32'(out_valid), 32'd0);
      check({tag, ".ir_back"}, 32'(in_ready),  32'd1);
   endtask

   initial begin
      reset_n    = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      carry_hist = 1'b0;
      out_ready  = 1'b0;
      #12;
      check("rst.ir",  32'(in_ready),    32'd1);
      check("rst.ov",  32'(out_valid),   32'd0);
      check("rst.bsy", 32'(busy),        32'd0);
      check("rst.mh",  32'(out_mask_hi), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;

      // scenario 1 with fixed expectations as an anchor for the model
      run_word("s1", 10'b1001100111, 1'b0, 0);
      check("s1.k_mh", 32'(out_mask_hi), 32'(exp_hi)); // held after handshake
      check("s1.k_hi", 32'(exp_hi), 32'(10'b0000000100));
      check("s1.k_lo", 32'(exp_lo), 32'(10'b1000100000));

      // all ones, then carried all ones
      run_word("s2a", 10'h3FF, 1'b0, 1);
      check("s2a.k_hi", 32'(out_mask_hi), 32'(10'b1111111100));
      run_word("s2b", 10'h3FF, 1'b1, 0);
      check("s2b.k_hi", 32'(out_mask_hi), 32'(10'h3FF));
      check("s2b.k_ch", 32'(out_cnt_hi),  32'd10);

      // zeros then a carried single one, and the same without carry
      run_word("s3a", 10'h000, 1'b0, 0);
      run_word("s3b", 10'b0000000001, 1'b1, 0);
      check("s3b.k_lo", 32'(out_mask_lo), 32'(10'b0000000001));
      run_word("s4a", 10'h000, 1'b0, 0);
      run_word("s4b", 10'b0000000001, 1'b0, 0);
      check("s4b.k_lo", 32'(out_mask_lo), 32'd0);

      // backpressure
      run_word("s5", 10'b1110001101, 1'b1, 5);

      // reset pulsed during the 4th shift cycle
      in_valid   = 1'b1;
      in_data    = 10'h3FF;
      carry_hist = 1'b0;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clock); #1;
      end
      reset_n = 1'b0;
      #1;
      check("ar.ov",  32'(out_valid),   32'd0);
      check("ar.bsy", 32'(busy),        32'd0);
      check("ar.ir",  32'(in_ready),    32'd1);
      check("ar.mh",  32'(out_mask_hi), 32'd0);
      check("ar.ch",  32'(out_cnt_hi),  32'd0);
      stream_q.delete();
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;
      // carry requested but history was cleared by reset
      run_word("s6", 10'b1001100111, 1'b1, 0);
      check("s6.k_lo", 32'(out_mask_lo), 32'(10'b1000100000));

      // randomized words
      for (int i = 0; i < 40; i++) begin
         run_word("rnd", W'($urandom), 1'($urandom), int'($urandom_range(0, 4)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
